mult_div_unit: RTL and testbench

- Execute-stage multiply/divide unit. It consumes the mult/multu/div/divu/mfhi/mflo/mthi/mtlo classes produced by the instruction decoder.
- It owns the architectural HI/LO registers and models fixed MIPS multi-cycle latency with a busy countdown.
- Hazard control stalls the D stage while busy|start is high and an MD-class instruction sits in D.

---
 rtl/mult_div_unit_pkg.sv | 38 +++
 rtl/mult_div_unit_md_arith.sv | 72 +++++++
 rtl/mult_div_unit.sv | 106 ++++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, default latencies, FSM states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package mult_div_unit_pkg;

  // md_op encodings driven by the control unit
  localparam logic [2:0] MD_OP_NONE  = 3'd0;
  localparam logic [2:0] MD_OP_MULT  = 3'd1;
  localparam logic [2:0] MD_OP_MULTU = 3'd2;
  localparam logic [2:0] MD_OP_DIV   = 3'd3;
  localparam logic [2:0] MD_OP_DIVU  = 3'd4;
  localparam logic [2:0] MD_OP_MTHI  = 3'd5;
  localparam logic [2:0] MD_OP_MTLO  = 3'd6;
  localparam logic [2:0] MD_OP_RSVD  = 3'd7;

  // Default busy durations in cycles
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Countdown width; wide enough for any sensible latency setting
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for multiple cycles
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational multiply/divide datapath producing the full 64-bit {hi,lo} result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; commit_en=0 flags divide-by-zero so HI/LO stay untouched.
module mult_div_unit_md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        commit_en
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [31:0]        div_n;
  logic [31:0]        div_d;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               b_zero;

  // Operand conditioning, products and a single shared unsigned divider
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    abs_a  = a[31] ? (~a + 32'd1) : a;
    abs_b  = b[31] ? (~b + 32'd1) : b;
    b_zero = (b == 32'd0);
    // Signed divide runs on magnitudes; 0x80000000 negates to itself, which is
    // the correct unsigned magnitude, so the overflow case needs no special path.
    div_n  = (op == MD_OP_DIV) ? abs_a : a;
    div_d  = (op == MD_OP_DIV) ? abs_b : b;
    // Never feed zero to the divider; the result is discarded in that case anyway
    if (b_zero) begin
      div_d = 32'd1;
    end
    quot_u = div_n / div_d;
    rem_u  = div_n % div_d;
  end

  // Select result per op; quotient truncates toward zero, remainder follows dividend sign
  always_comb begin
    res       = 64'd0;
    commit_en = 1'b0;
    case (op)
      MD_OP_MULT: begin
        res       = prod_s;
        commit_en = 1'b1;
      end
      MD_OP_MULTU: begin
        res       = prod_u;
        commit_en = 1'b1;
      end
      MD_OP_DIV: begin
        res[31:0]  = (a[31] ^ b[31]) ? (~quot_u + 32'd1) : quot_u;
        res[63:32] = a[31] ? (~rem_u + 32'd1) : rem_u;
        commit_en  = !b_zero;
      end
      MD_OP_DIVU: begin
        res       = {rem_u, quot_u};
        commit_en = !b_zero;
      end
      default: begin
        res       = 64'd0;
        commit_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO, with fixed MIPS-style latency.
// Latency: MULT/MULTU busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES; MTHI/MTLO visible next cycle.
// Backpressure: busy tells hazard logic to stall; any start while busy is dropped without side effects.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic               pend_en_q, pend_en_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0]        arith_res;
  logic               arith_en;

  mult_div_unit_md_arith u_md_arith (
    .op        (md_op),
    .a         (a),
    .b         (b),
    .res       (arith_res),
    .commit_en (arith_en)
  );

  // Next-state: accept ops in IDLE, count down in RUN, commit pending result on expiry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_en_d = pend_en_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith_op(md_op)) begin
            // Result is captured at acceptance so later operand changes are irrelevant
            pend_d    = arith_res;
            pend_en_d = arith_en;
            cnt_d     = is_div_op(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                         : CNT_W'(MULT_CYCLES - 1);
            state_d   = ST_RUN;
          end else if (md_op == MD_OP_MTHI) begin
            hi_d = a;
          end else if (md_op == MD_OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here: a stray request while busy is dropped
        if (cnt_q == '0) begin
          if (pend_en_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          pend_en_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight op and zeroes HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 64'd0;
      pend_en_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_en_q <= pend_en_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed table-driven bench for mult_div_unit plus hand sequences for stall and reset corners.
// Latency: checks exact busy cycle counts and HI/LO visibility after busy falls.
// Backpressure: exercises a start issued while busy, which must be ignored.
module tb_mult_div_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam int         BUSY_LIMIT = 100;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge: present a one-cycle request, return at the negedge after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    md_op = op;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    a     = 32'h5A5A_5A5A;
    b     = 32'hA5A5_A5A5;
  endtask

  // Counts negedges with busy high, bounded; optionally checks HI/LO hold steady meanwhile
  task automatic count_busy(input int already, input logic [31:0] old_hi,
                            input logic [31:0] old_lo, input string name, output int n);
    n = already;
    while (busy === 1'b1 && n < BUSY_LIMIT) begin
      if (hi !== old_hi || lo !== old_lo) begin
        check({name, "_hold_hi"}, hi, old_hi);
        check({name, "_hold_lo"}, lo, old_lo);
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    checks   = 0;
    failures = 0;

    //            op        a             b             busy hi            lo
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[4]  = '{OP_MTHI,  32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h00000003};
    vecs[5]  = '{OP_MTLO,  32'h00000000, 32'h00000000, 0,  32'h12345678, 32'h00000000};
    vecs[6]  = '{OP_DIV,   32'h00000064, 32'h00000000, 10, 32'h12345678, 32'h00000000};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[8]  = '{OP_NONE,  32'hDEADBEEF, 32'h00000001, 0,  32'h00000000, 32'h80000000};
    vecs[9]  = '{OP_RSVD,  32'hDEADBEEF, 32'h00000001, 0,  32'h00000000, 32'h80000000};
    vecs[10] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 10, 32'h00000005, 32'h19999999};
    vecs[12] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};

    reset = 1'b1;
    start = 1'b0;
    md_op = OP_NONE;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    prev_hi = 32'd0;
    prev_lo = 32'd0;
    // Back-to-back: each request is presented at the negedge where busy was seen low
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      count_busy(0, prev_hi, prev_lo, $sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      prev_hi = vecs[i].exp_hi;
      prev_lo = vecs[i].exp_lo;
    end

    // MTLO arriving mid-MULT must be dropped
    issue(OP_MULT, 32'd6, 32'd7);
    check("stall_busy_c1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    md_op = OP_MTLO;
    a     = 32'h0000AAAA;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    count_busy(2, prev_hi, prev_lo, "stall", n);
    check("stall_busy_cycles", 32'(n), 32'd5);
    check("stall_hi", hi, 32'd0);
    check("stall_lo", lo, 32'd42);

    // Reset in cycle 3 of a DIV discards it and zeroes HI/LO
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    // Stay idle past the point the discarded DIV would have finished
    repeat (10) @(negedge clk);
    check("rst_late_hi", hi, 32'd0);
    check("rst_late_lo", lo, 32'd0);

    issue(OP_MULT, 32'd3, 32'd4);
    count_busy(0, 32'd0, 32'd0, "post_rst", n);
    check("post_rst_busy_cycles", 32'(n), 32'd5);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
